if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC register, on-chip instruction memory, IF/ID latch.
// Ports: CLK/RST, STALL/FLUSH/BRANCH_* control, IMEM_* write port, PC/IF-ID/count outputs.
module if_fetch_unit #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int PC_STEP    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int CNT_W      = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              STALL,
  input  logic              FLUSH,
  input  logic              BRANCH_TAKEN,
  input  logic [ADDR_W-1:0] BRANCH_TARGET,
  input  logic              IMEM_WE,
  input  logic [ADDR_W-1:0] IMEM_WADDR,
  input  logic [DATA_W-1:0] IMEM_WDATA,
  output logic [ADDR_W-1:0] PC_OUT,
  output logic [ADDR_W-1:0] NEXT_INS_ADR_OUT,
  output logic [DATA_W-1:0] CUR_INS_OUT,
  output logic              INS_VALID_OUT,
  output logic [CNT_W-1:0]  FETCH_COUNT
);

  localparam int SH = $clog2(PC_STEP);
  localparam int IDX_W =
    (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] STEP =
    ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] LOW_MASK =
    ADDR_W'(PC_STEP - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A =
    ADDR_W'(IMEM_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] nadr;
    logic [DATA_W-1:0] ins;
    logic              valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{
    nadr:  '0,
    ins:   NOP_WORD,
    valid: 1'b0
  };

  logic [DATA_W-1:0] r_imem [IMEM_DEPTH];
  logic [ADDR_W-1:0] r_pc;
  if_id_t            r_ifid;
  logic [CNT_W-1:0]  r_cnt;

  logic [ADDR_W-1:0] w_ridx;
  logic [ADDR_W-1:0] w_widx;
  logic              w_rhit;
  logic              w_whit;
  logic [DATA_W-1:0] w_rdata;
  logic [ADDR_W-1:0] w_pc_seq;
  logic [ADDR_W-1:0] w_pc_nxt;
  if_id_t            w_ifid_nxt;
  logic              w_pc_br;
  logic              w_pc_hold;
  logic              w_pc_adv;
  logic              w_id_bub;
  logic              w_id_hold;
  logic              w_id_load;
  logic              w_cnt_max;

  assign w_ridx  = r_pc >> SH;
  assign w_widx  = IMEM_WADDR >> SH;
  assign w_rhit  = w_ridx < DEPTH_A;
  assign w_whit  = IMEM_WE && (w_widx < DEPTH_A);
  assign w_rdata = w_rhit
                 ? r_imem[w_ridx[IDX_W-1:0]]
                 : NOP_WORD;

  assign w_pc_seq = r_pc + STEP;

  // Mutually exclusive selects so the
  // decoders below are truly one-hot.
  assign w_pc_br   = BRANCH_TAKEN;
  assign w_pc_hold = !BRANCH_TAKEN && STALL;
  assign w_pc_adv  = !BRANCH_TAKEN && !STALL;

  // A branch squashes the fetch it redirects,
  // so it bubbles IF/ID just like FLUSH.
  assign w_id_bub  = BRANCH_TAKEN || FLUSH;
  assign w_id_hold = !w_id_bub && STALL;
  assign w_id_load = !w_id_bub && !STALL;

  assign w_cnt_max = &r_cnt;

  always_comb begin
    w_pc_nxt = r_pc;
    unique case (1'b1)
      w_pc_br:   w_pc_nxt = BRANCH_TARGET & ~LOW_MASK;
      w_pc_hold: w_pc_nxt = r_pc;
      w_pc_adv:  w_pc_nxt = w_pc_seq;
      default:   w_pc_nxt = r_pc;
    endcase
  end

  always_comb begin
    w_ifid_nxt = r_ifid;
    unique case (1'b1)
      w_id_bub:  w_ifid_nxt = BUBBLE;
      w_id_hold: w_ifid_nxt = r_ifid;
      w_id_load: begin
        w_ifid_nxt.nadr  = w_pc_seq;
        w_ifid_nxt.ins   = w_rdata;
        w_ifid_nxt.valid = 1'b1;
      end
      default:   w_ifid_nxt = r_ifid;
    endcase
  end

  // Memory is not reset; writes land even
  // while RST is asserted.
  always_ff @(posedge CLK) begin
    if (w_whit)
      r_imem[w_widx[IDX_W-1:0]] <= IMEM_WDATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc   <= RESET_PC & ~LOW_MASK;
      r_ifid <= BUBBLE;
      r_cnt  <= '0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_ifid <= w_ifid_nxt;
      if (w_id_load && !w_cnt_max)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign PC_OUT           = r_pc;
  assign NEXT_INS_ADR_OUT = r_ifid.nadr;
  assign CUR_INS_OUT      = r_ifid.ins;
  assign INS_VALID_OUT    = r_ifid.valid;
  assign FETCH_COUNT      = r_cnt;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed
// scenarios then random traffic vs. a reference model.
module tb_if_fetch_unit;

  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'h0;

  logic        CLK = 1'b0;
  logic        RST;
  logic        STALL;
  logic        FLUSH;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        IMEM_WE;
  logic [31:0] IMEM_WADDR;
  logic [31:0] IMEM_WDATA;

  logic [31:0] pc_o, nadr_o, ins_o;
  logic        val_o;
  logic [15:0] cnt_o;
  logic [31:0] s_pc_o, s_nadr_o, s_ins_o;
  logic        s_val_o;
  logic [1:0]  s_cnt_o;

  always #5 CLK = ~CLK;

  if_fetch_unit u_dut (
    .CLK(CLK), .RST(RST), .STALL(STALL),
    .FLUSH(FLUSH), .BRANCH_TAKEN(BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET),
    .IMEM_WE(IMEM_WE), .IMEM_WADDR(IMEM_WADDR),
    .IMEM_WDATA(IMEM_WDATA), .PC_OUT(pc_o),
    .NEXT_INS_ADR_OUT(nadr_o),
    .CUR_INS_OUT(ins_o), .INS_VALID_OUT(val_o),
    .FETCH_COUNT(cnt_o)
  );

  if_fetch_unit #(.CNT_W(2)) u_sat (
    .CLK(CLK), .RST(RST), .STALL(STALL),
    .FLUSH(FLUSH), .BRANCH_TAKEN(BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET),
    .IMEM_WE(IMEM_WE), .IMEM_WADDR(IMEM_WADDR),
    .IMEM_WDATA(IMEM_WDATA), .PC_OUT(s_pc_o),
    .NEXT_INS_ADR_OUT(s_nadr_o),
    .CUR_INS_OUT(s_ins_o), .INS_VALID_OUT(s_val_o),
    .FETCH_COUNT(s_cnt_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] nadr;
    logic [31:0] ins;
    logic        valid;
    int          cnt;
  } exp_t;

  exp_t q[$];

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc;
  logic [31:0] m_nadr;
  logic [31:0] m_ins;
  logic        m_valid;
  int          m_cnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  function automatic int sat(input int c,
                             input int mx);
    return (c > mx) ? mx : c;
  endfunction

  task automatic step(input logic rst,
                      input logic stall,
                      input logic flush,
                      input logic br,
                      input logic [31:0] tgt,
                      input logic we,
                      input logic [31:0] wa,
                      input logic [31:0] wd);
    logic [31:0] word;
    exp_t e;
    @(negedge CLK);
    RST           = rst;
    STALL         = stall;
    FLUSH         = flush;
    BRANCH_TAKEN  = br;
    BRANCH_TARGET = tgt;
    IMEM_WE       = we;
    IMEM_WADDR    = wa;
    IMEM_WDATA    = wd;
    word = (m_pc / 4 < DEPTH)
         ? m_mem[m_pc / 4] : NOP;
    if (rst) begin
      m_pc    = 32'h0;
      m_nadr  = 32'h0;
      m_ins   = NOP;
      m_valid = 1'b0;
      m_cnt   = 0;
    end else begin
      if (br || flush) begin
        m_nadr  = 32'h0;
        m_ins   = NOP;
        m_valid = 1'b0;
      end else if (!stall) begin
        m_nadr  = m_pc + 32'd4;
        m_ins   = word;
        m_valid = 1'b1;
        m_cnt++;
      end
      if (br)
        m_pc = {tgt[31:2], 2'b00};
      else if (!stall)
        m_pc = m_pc + 32'd4;
    end
    if (we && (wa / 4 < DEPTH))
      m_mem[wa / 4] = wd;
    e.pc    = m_pc;
    e.nadr  = m_nadr;
    e.ins   = m_ins;
    e.valid = m_valid;
    e.cnt   = m_cnt;
    q.push_back(e);
  endtask

  task automatic adv();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", pc_o, e.pc);
        chk("next_adr", nadr_o, e.nadr);
        chk("ins", ins_o, e.ins);
        chk("valid", 32'(val_o), 32'(e.valid));
        chk("count", 32'(cnt_o),
            32'(sat(e.cnt, 65535)));
        chk("sat_pc", s_pc_o, e.pc);
        chk("sat_ins", s_ins_o, e.ins);
        chk("sat_count", 32'(s_cnt_o),
            32'(sat(e.cnt, 3)));
      end
    end
  end

  initial begin : driver
    logic [31:0] tgt;
    RST = 1'b1;
    STALL = 1'b0;
    FLUSH = 1'b0;
    BRANCH_TAKEN = 1'b0;
    BRANCH_TARGET = '0;
    IMEM_WE = 1'b0;
    IMEM_WADDR = '0;
    IMEM_WDATA = '0;
    m_pc = 0;
    m_nadr = 0;
    m_ins = NOP;
    m_valid = 0;
    m_cnt = 0;
    for (int i = 0; i < DEPTH; i++)
      m_mem[i] = 32'h0;

    // Fill memory while in reset; low address
    // bits vary to show they are ignored.
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] d;
      d = (i < 4) ? 32'(17 * (i + 1))
                  : $urandom;
      step(1, 0, 0, 0, 0, 1,
           32'(i * 4) | 32'($urandom_range(0, 3)),
           d);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0);

    adv();
    adv();
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    adv();
    step(0, 1, 0, 1, 32'h0D, 0, 0, 0);
    adv();
    step(0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h100, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h100, 32'hDEAD);
    step(0, 0, 0, 0, 0, 1, 32'h102, 32'hBEEF);
    repeat (5) adv();
    step(0, 0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0);
    adv();
    adv();
    step(1, 1, 1, 1, 32'h40, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h0, 32'h55);
    step(0, 0, 0, 1, 32'h0, 0, 0, 0);
    adv();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 10 == 0)
        tgt = 32'hFFFF_FF00 | 32'($urandom % 256);
      else
        tgt = 32'($urandom_range(0, 32'h11F));
      step($urandom % 50 == 0,
           $urandom % 5 == 0,
           $urandom % 10 == 0,
           $urandom % 8 == 0,
           tgt,
           $urandom % 3 == 0,
           32'($urandom_range(0, 32'h11F)),
           $urandom);
    end

    repeat (3) @(posedge CLK);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d want 0",
               q.size());
    end
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
